mig_app_responder: RTL and testbench
====================================

Name: mig_app_responder

Overview:
- Cycle-accurate, synthesizable model of the memory-controller side of the 256-bit DDR3 user (app) interface. Used in place of the memory-interface IP in simulation and loopback builds.
- Accepts write/read commands, buffers write data, stores it in an internal word array, and returns read data in order after a fixed latency.
- Generates calibration-done, ready backpressure and protocol-error flags so that user-side state machines can be exercised without DDR3.

Parameters:
- DEPTH, 64: number of 256-bit words in the internal array; power of 2.
- CMD_DEPTH, 4: command queue entries; power of 2.
- WDF_DEPTH, 4: write-data FIFO entries; power of 2.
- RD_LAT, 6: cycles from read issue to app_rd_data_valid; ≥1.
- CALIB_CYCLES, 16: cycles after reset release before init_calib_complete rises.
- STALL_PERIOD, 0: app_rdy forced low for 1 cycle every STALL_PERIOD cycles; 0 = never.

Ports:
- ui_clk  in  1  sole clock.
- ui_clk_sync_rst  in  1  synchronous, active-high reset.
- app_addr  in  29  byte-granular address; one word = 8 address units.
- app_cmd  in  3  3'b000 write, 3'b001 read; all other codes are illegal.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en && app_rdy.
- app_wdf_data  in  256  write data.
- app_wdf_mask  in  32  1 = byte NOT written.
- app_wdf_wren  in  1  write-data valid.
- app_wdf_end  in  1  must equal app_wdf_wren.
- app_wdf_rdy  out  1  data accepted when app_wdf_wren && app_wdf_rdy.
- app_rd_data  out  256  read data.
- app_rd_data_valid  out  1  read data strobe.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  interface usable.
- proto_error  out  1  sticky protocol violation flag.

Behaviour:
- Reset (synchronous): all outputs 0, including app_rd_data. Queues are emptied, the in-flight read pipeline is flushed, and the calibration counter restarts. Array contents are retained, not cleared.
- Calibration: init_calib_complete rises exactly CALIB_CYCLES cycles after the first cycle with reset low. It then stays high until reset.
- Word index = app_addr[3 +: log2(DEPTH)]. Bits [2:0] and any bits above the index are ignored, so addresses alias modulo DEPTH words.
- app_rdy = init_calib_complete && cmd queue not full && !stall_slot.
  - stall_slot is high one cycle in every STALL_PERIOD, counted by a free-running counter that starts at calibration done.
  - app_rdy is registered: it reflects occupancy at the start of the cycle.
- app_wdf_rdy = init_calib_complete && write-data FIFO not full (registered the same way).
- Command acceptance:
  - An accepted legal command is pushed {cmd, word index} and becomes the queue head visible in the next cycle.
  - An accepted illegal cmd is dropped and sets proto_error.
  - app_en while app_rdy is low is ignored (the user must hold its command) and is not an error.
- Write data: an accepted beat pushes {data, mask} into the write-data FIFO. Data may arrive up to WDF_DEPTH beats before its command.
  - app_wdf_end != app_wdf_wren in any cycle sets proto_error.
  - app_wdf_wren while app_wdf_rdy is low is ignored.
- Head processing (at most one command per cycle, strictly in order):
  - Head = read: issued immediately. The array word is sampled in the issue cycle and enters an RD_LAT-stage pipeline. app_rd_data_valid and app_rd_data_end pulse RD_LAT cycles later.
  - Head = write: commits only when the write-data FIFO is non-empty. The FIFO head and the command pop together, and only unmasked bytes are written. If the FIFO is empty, the head blocks and later commands wait; this is head-of-line blocking.
- Latency: an uncontested read accepted in cycle t gives valid in cycle t+1+RD_LAT. A write committed in cycle c is visible to a read issued in cycle c+1 or later; in-order processing guarantees read-after-write ordering.
- Simultaneous push and pop on the same queue in one cycle is allowed, with occupancy unchanged, including when the queue is full. The full flag deasserts the cycle after a pop.
- Write data left in the FIFO at reset is discarded. Read data returns exactly once per accepted read command.

Test Plan:
- Reset release: init_calib_complete rises at cycle 16 (not 15). app_rdy and app_wdf_rdy go high in the same cycle; all outputs are 0 beforehand.
- Write 10 words: addr 0, 8, …, 72 with data 0, 2, …, 18. Then read the same 10 addresses: 10 valid pulses in order carrying 0, 2, …, 18, first valid 7 cycles after the first read is accepted, with app_rd_data_end == app_rd_data_valid.
- Issue a write command with no data, then 3 reads: app_rdy drops once the queue holds 4. Supply the data 5 cycles later: the write commits, then the reads drain and return the new value for the matching address.
- Send 4 data beats with wren only, no command: app_wdf_rdy drops on the 5th. Masked write with mask=32'h0000_000F over 256'hFF…FF onto word 0: the read returns the low 4 bytes unchanged and the rest 0xFF.
- app_cmd=3'b010 accepted: proto_error set, no data returned. app_wdf_end=1 with wren=0: proto_error stays set until reset.
- STALL_PERIOD=5 with app_en held high: app_rdy is low exactly 1 cycle in every 5. Reset asserted with 3 reads in flight: no valid is produced afterward, and array contents written earlier read back intact.

Source files
------------

// File: rtl/mig_app_responder.sv
// Simulation/loopback stand-in for the controller side of a 256-bit DDR3 app
// interface: command queue, write-data FIFO, word array and a fixed-latency
// in-order read return path, plus calibration, backpressure and error flags.
module mig_app_responder #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned CMD_DEPTH    = 4,
    parameter int unsigned WDF_DEPTH    = 4,
    parameter int unsigned RD_LAT       = 6,
    parameter int unsigned CALIB_CYCLES = 16,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic         ui_clk,
    input  logic         ui_clk_sync_rst,
    input  logic [28:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    output logic         app_rdy,
    input  logic [255:0] app_wdf_data,
    input  logic [31:0]  app_wdf_mask,
    input  logic         app_wdf_wren,
    input  logic         app_wdf_end,
    output logic         app_wdf_rdy,
    output logic [255:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    output logic         init_calib_complete,
    output logic         proto_error
);

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned CQ_W       = $clog2(CMD_DEPTH);
    localparam int unsigned WQ_W       = $clog2(WDF_DEPTH);
    localparam int unsigned CAL_W      = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned ST_W       = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int unsigned STALL_LAST = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        PH_CALIB,
        PH_RUN
    } phase_t;

    phase_t            phase, phase_next;
    logic [CAL_W-1:0]  calib_cnt, calib_cnt_next;
    logic [ST_W-1:0]   stall_cnt, stall_cnt_next;
    logic              calib_next, stall_next;

    logic [255:0]      mem [DEPTH];

    logic [2:0]        cq_cmd [CMD_DEPTH];
    logic [IDX_W-1:0]  cq_idx [CMD_DEPTH];
    logic [CQ_W-1:0]   cq_wr_ptr, cq_rd_ptr;
    logic [CQ_W:0]     cq_count, cq_count_next;

    logic [255:0]      wq_data [WDF_DEPTH];
    logic [31:0]       wq_mask [WDF_DEPTH];
    logic [WQ_W-1:0]   wq_wr_ptr, wq_rd_ptr;
    logic [WQ_W:0]     wq_count, wq_count_next;

    logic [RD_LAT-1:0] rd_valid_pipe;
    logic [255:0]      rd_data_pipe [RD_LAT];

    logic [IDX_W-1:0]  addr_idx, head_idx;
    logic              addr_unused;
    logic              cmd_legal, cmd_accept, cq_push, cq_pop;
    logic              head_valid, head_is_read, rd_issue, wr_commit;
    logic              wq_push, wq_pop;

    assign addr_idx    = app_addr[3 +: IDX_W];
    assign addr_unused = ^{app_addr[2:0], app_addr[28:3]};

    assign cmd_legal    = (app_cmd == CMD_WRITE) || (app_cmd == CMD_READ);
    assign cmd_accept   = app_en && app_rdy;
    assign cq_push      = cmd_accept && cmd_legal;
    assign head_valid   = (cq_count != '0);
    assign head_is_read = (cq_cmd[cq_rd_ptr] == CMD_READ);
    assign head_idx     = cq_idx[cq_rd_ptr];
    assign rd_issue     = head_valid && head_is_read;
    assign wr_commit    = head_valid && !head_is_read && (wq_count != '0);
    assign cq_pop       = rd_issue || wr_commit;
    assign wq_push      = app_wdf_wren && app_wdf_rdy;
    assign wq_pop       = wr_commit;

    assign init_calib_complete = (phase == PH_RUN);
    assign app_rd_data_valid   = rd_valid_pipe[RD_LAT-1];
    assign app_rd_data_end     = rd_valid_pipe[RD_LAT-1];
    assign app_rd_data         = rd_data_pipe[RD_LAT-1];

    // Calibration phase state register and stall-slot counter.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            phase     <= PH_CALIB;
            calib_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            phase     <= phase_next;
            calib_cnt <= calib_cnt_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    // Phase transition after CALIB_CYCLES; stall counter runs only once calibrated.
    always_comb begin
        phase_next     = phase;
        calib_cnt_next = calib_cnt;
        stall_cnt_next = '0;
        unique case (phase)
            PH_CALIB: begin
                if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                    phase_next = PH_RUN;
                end else begin
                    calib_cnt_next = calib_cnt + CAL_W'(1);
                end
            end
            PH_RUN: begin
                stall_cnt_next = (stall_cnt == ST_W'(STALL_LAST)) ? '0 : stall_cnt + ST_W'(1);
            end
            default: phase_next = PH_CALIB;
        endcase
        calib_next = (phase_next == PH_RUN);
        stall_next = (STALL_PERIOD != 0) && calib_next && (stall_cnt_next == ST_W'(STALL_LAST));
    end

    // Next occupancy of both queues; push and pop together leave it unchanged.
    always_comb begin
        cq_count_next = cq_count;
        wq_count_next = wq_count;
        if (cq_push && !cq_pop) cq_count_next = cq_count + (CQ_W + 1)'(1);
        if (cq_pop && !cq_push) cq_count_next = cq_count - (CQ_W + 1)'(1);
        if (wq_push && !wq_pop) wq_count_next = wq_count + (WQ_W + 1)'(1);
        if (wq_pop && !wq_push) wq_count_next = wq_count - (WQ_W + 1)'(1);
    end

    // Queue pointers, registered ready flags computed from next-cycle occupancy, sticky error.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            cq_wr_ptr   <= '0;
            cq_rd_ptr   <= '0;
            cq_count    <= '0;
            wq_wr_ptr   <= '0;
            wq_rd_ptr   <= '0;
            wq_count    <= '0;
            app_rdy     <= 1'b0;
            app_wdf_rdy <= 1'b0;
            proto_error <= 1'b0;
        end else begin
            if (cq_push) cq_wr_ptr <= cq_wr_ptr + CQ_W'(1);
            if (cq_pop)  cq_rd_ptr <= cq_rd_ptr + CQ_W'(1);
            if (wq_push) wq_wr_ptr <= wq_wr_ptr + WQ_W'(1);
            if (wq_pop)  wq_rd_ptr <= wq_rd_ptr + WQ_W'(1);
            cq_count    <= cq_count_next;
            wq_count    <= wq_count_next;
            app_rdy     <= calib_next && (cq_count_next != (CQ_W + 1)'(CMD_DEPTH)) && !stall_next;
            app_wdf_rdy <= calib_next && (wq_count_next != (WQ_W + 1)'(WDF_DEPTH));
            if ((cmd_accept && !cmd_legal) || (app_wdf_end != app_wdf_wren)) begin
                proto_error <= 1'b1;
            end
        end
    end

    // Read return pipeline; the array word is captured in the issue cycle.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            rd_valid_pipe <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) rd_data_pipe[i] <= '0;
        end else begin
            rd_valid_pipe[0] <= rd_issue;
            rd_data_pipe[0]  <= rd_issue ? mem[head_idx] : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rd_valid_pipe[i] <= rd_valid_pipe[i-1];
                rd_data_pipe[i]  <= rd_data_pipe[i-1];
            end
        end
    end

    // Queue payload storage and the word array; contents survive reset.
    always_ff @(posedge ui_clk) begin
        if (!ui_clk_sync_rst) begin
            if (cq_push) begin
                cq_cmd[cq_wr_ptr] <= app_cmd;
                cq_idx[cq_wr_ptr] <= addr_idx;
            end
            if (wq_push) begin
                wq_data[wq_wr_ptr] <= app_wdf_data;
                wq_mask[wq_wr_ptr] <= app_wdf_mask;
            end
            if (wr_commit) begin
                for (int unsigned b = 0; b < 32; b++) begin
                    if (!wq_mask[wq_rd_ptr][b]) begin
                        mem[head_idx][b*8 +: 8] <= wq_data[wq_rd_ptr][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: read expectations go into a queue at
// command acceptance and a negedge monitor pops and compares each returned beat.
module tb_mig_app_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [28:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         st_en = 1'b0;
    logic [255:0] app_wdf_data = '0;
    logic [31:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic         init_calib_complete, proto_error;
    logic [255:0] app_rd_data;

    logic         st_rdy;
    logic         st_wdf_rdy_unused, st_valid_unused, st_end_unused, st_calib_unused, st_proto_unused;
    logic [255:0] st_data_unused;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           valid_total = 0;
    logic [255:0] exp_q[$];
    int           valid_cycs[$];
    logic [255:0] mon_exp;

    localparam logic [255:0] D3 = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    mig_app_responder dut (
        .ui_clk             (clk),
        .ui_clk_sync_rst    (rst),
        .app_addr           (app_addr),
        .app_cmd            (app_cmd),
        .app_en             (app_en),
        .app_rdy            (app_rdy),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_mask       (app_wdf_mask),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_rd_data        (app_rd_data),
        .app_rd_data_valid  (app_rd_data_valid),
        .app_rd_data_end    (app_rd_data_end),
        .init_calib_complete(init_calib_complete),
        .proto_error        (proto_error)
    );

    mig_app_responder #(.STALL_PERIOD(5)) dut_stall (
        .ui_clk             (clk),
        .ui_clk_sync_rst    (rst),
        .app_addr           (app_addr),
        .app_cmd            (app_cmd),
        .app_en             (st_en),
        .app_rdy            (st_rdy),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_mask       (app_wdf_mask),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_rdy        (st_wdf_rdy_unused),
        .app_rd_data        (st_data_unused),
        .app_rd_data_valid  (st_valid_unused),
        .app_rd_data_end    (st_end_unused),
        .init_calib_complete(st_calib_unused),
        .proto_error        (st_proto_unused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every returned beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (app_rd_data_valid || app_rd_data_end) begin
            checks++;
            if (app_rd_data_end !== app_rd_data_valid) begin
                errors++;
                $display("FAIL rd_end: got end=%b expected end=%b (valid)", app_rd_data_end, app_rd_data_valid);
            end
        end
        if (app_rd_data_valid === 1'b1) begin
            valid_total++;
            valid_cycs.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got unexpected beat %h expected no beat", app_rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (app_rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", app_rd_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected DUT response", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [28:0] a, output int acc_cyc);
        logic r;
        bit   done;
        done     = 1'b0;
        acc_cyc  = 0;
        app_en   = 1'b1;
        app_cmd  = c;
        app_addr = a;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            r       = app_rdy;
            acc_cyc = cyc;
            step();
            if (r) done = 1'b1;
        end
        app_en = 1'b0;
        if (!done) fail_timeout("cmd_accept");
    endtask

    task automatic send_read(input logic [28:0] a, input logic [255:0] e, output int acc_cyc);
        send_cmd(3'b001, a, acc_cyc);
        exp_q.push_back(e);
    endtask

    task automatic send_data(input logic [255:0] d, input logic [31:0] m);
        logic r;
        bit   done;
        done         = 1'b0;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = d;
        app_wdf_mask = m;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            r = app_wdf_rdy;
            step();
            if (r) done = 1'b1;
        end
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        if (!done) fail_timeout("wdf_accept");
    endtask

    task automatic send_write(input logic [28:0] a, input logic [255:0] d, input logic [31:0] m);
        logic rc, rd;
        bit   cdone, ddone;
        cdone = 1'b0;
        ddone = 1'b0;
        app_en = 1'b1;  app_cmd = 3'b000;  app_addr = a;
        app_wdf_wren = 1'b1;  app_wdf_end = 1'b1;  app_wdf_data = d;  app_wdf_mask = m;
        for (int i = 0; i < 200 && !(cdone && ddone); i++) begin
            @(negedge clk);
            rc = app_rdy && app_en;
            rd = app_wdf_rdy && app_wdf_wren;
            step();
            if (rc) begin cdone = 1'b1; app_en = 1'b0; end
            if (rd) begin ddone = 1'b1; app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
        end
        app_en = 1'b0;  app_wdf_wren = 1'b0;  app_wdf_end = 1'b0;
        if (!(cdone && ddone)) fail_timeout("write_accept");
    endtask

    task automatic wait_calib();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (init_calib_complete) done = 1'b1;
            step();
        end
        if (!done) fail_timeout("calib");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_calib();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) fail_timeout("read_drain");
        repeat (3) step();
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           acc, first_acc, v0;
        int           lows[$];
        logic [255:0] mexp;

        // Reset release and calibration timing.
        repeat (4) step();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("pre_calib_outputs",
                256'({init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid,
                      app_rd_data_end, proto_error, |app_rd_data}), 256'(0));
            step();
        end
        @(negedge clk);
        chk("calib_rdy_at_16", 256'({init_calib_complete, app_rdy, app_wdf_rdy}), 256'(3'b111));
        step();

        // Ten writes then ten reads, checking order and latency.
        for (int i = 0; i < 10; i++) send_write(29'(8 * i), 256'(2 * i), '0);
        valid_cycs.delete();
        first_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send_read(29'(8 * i), 256'(2 * i), acc);
            if (i == 0) first_acc = acc;
        end
        wait_drain();
        chk("rd_count", 256'(valid_cycs.size()), 256'(10));
        if (valid_cycs.size() > 0) chk("first_rd_latency", 256'(valid_cycs[0] - first_acc), 256'(7));

        // Head-of-line blocking: write with no data followed by three reads.
        send_cmd(3'b000, 29'd24, acc);
        send_read(29'd24, D3, acc);
        send_read(29'd0, 256'd0, acc);
        send_read(29'd40, 256'd10, acc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rdy_low_cmdq_full", 256'(app_rdy), 256'(0));
            step();
        end
        send_data(D3, '0);
        wait_drain();
        @(negedge clk);
        chk("rdy_back_after_drain", 256'(app_rdy), 256'(1));
        step();

        // Data ahead of commands fills the FIFO; a beat offered while full is ignored.
        send_data(256'h11, '0);
        send_data(256'h22, '0);
        send_data(256'h33, '0);
        send_data(256'h44, '0);
        @(negedge clk);
        chk("wdf_rdy_low_when_full", 256'(app_wdf_rdy), 256'(0));
        step();
        app_wdf_wren = 1'b1;  app_wdf_end = 1'b1;  app_wdf_data = 256'h55;
        repeat (2) step();
        app_wdf_wren = 1'b0;  app_wdf_end = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(3'b000, 29'(80 + 8 * i), acc);
        send_write(29'd0, '1, 32'h0000_000F);
        mexp = '1;
        mexp[31:0] = '0;
        send_read(29'd80, 256'h11, acc);
        send_read(29'd88, 256'h22, acc);
        send_read(29'd96, 256'h33, acc);
        send_read(29'd104, 256'h44, acc);
        send_read(29'd0, mexp, acc);
        wait_drain();

        // Illegal command sets the sticky error and returns nothing.
        @(negedge clk);
        chk("proto_clear_before", 256'(proto_error), 256'(0));
        step();
        v0 = valid_total;
        send_cmd(3'b010, 29'd0, acc);
        @(negedge clk);
        chk("proto_illegal_cmd", 256'(proto_error), 256'(1));
        step();
        repeat (12) step();
        chk("illegal_no_data", 256'(valid_total - v0), 256'(0));

        // Reset clears the flag; wdf_end without wren sets it again and it sticks.
        do_reset();
        @(negedge clk);
        chk("proto_cleared_by_reset", 256'(proto_error), 256'(0));
        step();
        app_wdf_end = 1'b1;
        step();
        app_wdf_end = 1'b0;
        @(negedge clk);
        chk("proto_wdf_end", 256'(proto_error), 256'(1));
        step();
        repeat (5) step();
        @(negedge clk);
        chk("proto_sticky", 256'(proto_error), 256'(1));
        step();

        // Periodic stall on the STALL_PERIOD=5 instance with app_en held high.
        app_cmd  = 3'b001;
        app_addr = 29'd0;
        st_en    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!st_rdy) lows.push_back(k);
            step();
        end
        st_en = 1'b0;
        chk("stall_low_count", 256'(lows.size()), 256'(4));
        for (int k = 1; k < lows.size(); k++) chk("stall_spacing", 256'(lows[k] - lows[k-1]), 256'(5));

        // Reset with reads in flight: nothing returns, array contents survive.
        send_cmd(3'b001, 29'd24, acc);
        send_cmd(3'b001, 29'd0, acc);
        send_cmd(3'b001, 29'd40, acc);
        v0 = valid_total;
        do_reset();
        repeat (10) step();
        chk("no_valid_after_reset", 256'(valid_total - v0), 256'(0));
        send_read(29'd24, D3, acc);
        send_read(29'd0, mexp, acc);
        send_read(29'd40, 256'd10, acc);
        send_read(29'd104, 256'h44, acc);
        wait_drain();
        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
